exe_mem_pipe_reg: RTL and testbench
===================================

# exe_mem_pipe_reg

Parametrised EXE→MEM pipeline register for the 5-stage core, replacing the fixed-width, always-load stage register. It carries the EXE results and MEM/WB control bits and adds a valid/ready handshake backed by a 2-entry skid buffer, so a stalled MEM stage does not need a combinational ready path back into EXE. It also supports a synchronous flush for branch squash, and exports destination info for the hazard/forwarding unit.

## Interface
- DATA_W, 32, width of alu_res and val_rm
- ADDR_W, 32, width of br_addr
- DEST_W, 4, width of destination register index
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous squash of all held and incoming entries
- in_valid  in  1  EXE presents an entry
- in_ready  out  1  register can accept; registered, no combinational path from out_ready
- wb_en_in, mem_read_en_in, mem_write_en_in  in  1 each  control bits
- alu_res_in  in  DATA_W  ALU result
- val_rm_in  in  DATA_W  store data
- br_addr_in  in  ADDR_W  branch target
- dest_in  in  DEST_W  writeback register index
- out_valid  out  1  MEM-side entry valid
- out_ready  in  1  MEM accepts entry this cycle
- wb_en, mem_read_en, mem_write_en  out  1 each  control bits, forced 0 when out_valid=0
- alu_res, val_rm  out  DATA_W  head entry data
- br_addr  out  ADDR_W  head entry branch target
- dest  out  DEST_W  head entry destination
- fwd_wb_en  out  1  = wb_en (already gated by out_valid), for forwarding
- fwd_dest  out  DEST_W  = dest
- occupancy  out  2  entries held (0, 1, 2)

## Operation
- Storage: main register (drives outputs) and skid register, each with its own valid bit.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = !skid_valid; out_valid = main_valid.
- States by occupancy:
  - EMPTY: in_fire → load main → ONE.
  - ONE:
    - in_fire & out_fire → load main → stay ONE.
    - in_fire only → load skid → TWO.
    - out_fire only → EMPTY.
  - TWO:
    - in_ready=0.
    - out_fire → main ← skid, skid invalid → ONE.
- Loading an entry copies all fields: the three control bits, alu_res, val_rm, br_addr and dest.
- Invalidating main (drain to EMPTY or flush) clears main's control bits to 0.
- Data fields and dest retain their last value when main is invalidated; only rst zeroes them.
- flush=1:
  - Both valids cleared at the edge → EMPTY.
  - A simultaneous in_fire is discarded.
  - A simultaneous out_fire still counts as consumed by MEM; no replay.
- No entry is duplicated or dropped except by flush.
- Order is strictly FIFO: skid is always younger than main.

## Timing
- Reset (async): all valids 0, all outputs 0, in_ready=1, occupancy=0.
- Latency: an entry accepted at edge N appears on outputs after edge N when arriving in EMPTY or ONE-with-out_fire.
- An entry parked in skid appears one edge after the out_fire of its predecessor.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- in_ready is a pure register output.
  - It deasserts the cycle after the second entry is captured.
  - It reasserts the cycle after the out_fire from TWO.
- Output fields are stable while out_valid=1 and out_ready=0.
- Rst asserted mid-transfer aborts everything immediately: outputs go 0 without waiting for clk.
- Flush has priority over all loads; rst has priority over flush.

## Test plan
- Reset then stream: out_ready=1, feed alu_res_in=0x10,0x11,0x12 on consecutive cycles → outputs show 0x10,0x11,0x12 one cycle later each; occupancy stays 1; in_ready stays 1.
- Backpressure fill: out_ready=0, feed 0xA0 then 0xA1 → occupancy=2, in_ready=0; a third in_valid with 0xA2 is not accepted; outputs hold 0xA0.
- Drain from full: continuing from the fill, raise out_ready=1 → 0xA0 consumed, then 0xA1, then EMPTY.
  - in_ready=1 from the cycle after the first out_fire.
  - wb_en=0 once out_valid=0.
- Flush with full buffer plus an incoming entry (wb_en_in=1, dest_in=5):
  - Next cycle: out_valid=0, wb_en=fwd_wb_en=0, occupancy=0.
  - The incoming entry never appears.
- Async reset mid-stream: rst pulsed between clock edges while occupancy=2 → all outputs 0 and in_ready=1 before the next edge.
- Parameter sweep: DATA_W=64, DEST_W=5 with alu_res_in=0xFFFF_FFFF_0000_0001, dest_in=31 → value passes through intact.

Source files
------------

// File: rtl/exe_mem_pipe_reg.sv
// ============================================================================
// exe_mem_pipe_reg : EXE->MEM stage register with valid/ready handshake and
//                    2-entry skid buffer, synchronous flush, forwarding taps.
// Revision 1.0 - initial parametrised handshake version
// ============================================================================
`default_nettype none

module exe_mem_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEST_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              wb_en_in,
    input  logic              mem_read_en_in,
    input  logic              mem_write_en_in,
    input  logic [DATA_W-1:0] alu_res_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic [ADDR_W-1:0] br_addr_in,
    input  logic [DEST_W-1:0] dest_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wb_en,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [DATA_W-1:0] alu_res,
    output logic [DATA_W-1:0] val_rm,
    output logic [ADDR_W-1:0] br_addr,
    output logic [DEST_W-1:0] dest,
    output logic              fwd_wb_en,
    output logic [DEST_W-1:0] fwd_dest,
    output logic [1:0]        occupancy
);

    // Entry layout, MSB first: {wb_en, mem_read_en, mem_write_en, alu_res, val_rm, br_addr, dest}
    localparam int ENT_W = 3 + 2 * DATA_W + ADDR_W + DEST_W;

    logic [ENT_W-1:0] main_q, main_d;
    logic [ENT_W-1:0] skid_q, skid_d;
    logic [ENT_W-1:0] in_ent;
    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q;
    logic             in_fire, out_fire;
    logic             main_wb, main_rd, main_wr;

    assign in_ent   = {wb_en_in, mem_read_en_in, mem_write_en_in,
                       alu_res_in, val_rm_in, br_addr_in, dest_in};
    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = main_valid_q & out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            // Data fields survive a squash; only the control bits are cleared.
            main_valid_d          = 1'b0;
            skid_valid_d          = 1'b0;
            main_d[ENT_W-1 -: 3]  = 3'b000;
        end else if (!main_valid_q) begin
            if (in_fire) begin
                main_d       = in_ent;
                main_valid_d = 1'b1;
            end
        end else if (!skid_valid_q) begin
            if (in_fire && out_fire) begin
                main_d = in_ent;
            end else if (in_fire) begin
                skid_d       = in_ent;
                skid_valid_d = 1'b1;
            end else if (out_fire) begin
                main_valid_d          = 1'b0;
                main_d[ENT_W-1 -: 3]  = 3'b000;
            end
        end else if (out_fire) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            // Registered copy of !skid_valid keeps out_ready off the in_ready path.
            in_ready_q   <= !skid_valid_d;
        end
    end

    assign {main_wb, main_rd, main_wr, alu_res, val_rm, br_addr, dest} = main_q;

    assign in_ready     = in_ready_q;
    assign out_valid    = main_valid_q;
    assign wb_en        = main_wb & main_valid_q;
    assign mem_read_en  = main_rd & main_valid_q;
    assign mem_write_en = main_wr & main_valid_q;
    assign fwd_wb_en    = wb_en;
    assign fwd_dest     = dest;
    assign occupancy    = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

`default_nettype wire

// File: tb/tb_exe_mem_pipe_reg.sv
// ============================================================================
// tb_exe_mem_pipe_reg : scoreboard bench for exe_mem_pipe_reg (default and
//                       wide parameter sets).
// Revision 1.0 - initial
// ============================================================================
`default_nettype none

module tb_exe_mem_pipe_reg;

    typedef struct packed {
        logic        wb;
        logic        rd;
        logic        wr;
        logic [31:0] alu;
        logic [31:0] val;
        logic [31:0] br;
        logic [3:0]  dst;
    } ent_t;

    logic        clk, rst, flush;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic        wb_en_in, mem_read_en_in, mem_write_en_in;
    logic [31:0] alu_res_in, val_rm_in, br_addr_in;
    logic [3:0]  dest_in;
    logic        wb_en, mem_read_en, mem_write_en, fwd_wb_en;
    logic [31:0] alu_res, val_rm, br_addr;
    logic [3:0]  dest, fwd_dest;
    logic [1:0]  occupancy;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [63:0] w_alu_in, w_alu, w_val;
    logic [31:0] w_br;
    logic [4:0]  w_dest_in, w_dest, w_fwd_dest;
    logic        w_wb, w_rd, w_wr, w_fwd_wb;
    logic [1:0]  w_occ;

    int checks   = 0;
    int failures = 0;
    ent_t sb[$];

    exe_mem_pipe_reg u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .wb_en_in(wb_en_in), .mem_read_en_in(mem_read_en_in), .mem_write_en_in(mem_write_en_in),
        .alu_res_in(alu_res_in), .val_rm_in(val_rm_in), .br_addr_in(br_addr_in), .dest_in(dest_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_en(wb_en), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .alu_res(alu_res), .val_rm(val_rm), .br_addr(br_addr), .dest(dest),
        .fwd_wb_en(fwd_wb_en), .fwd_dest(fwd_dest), .occupancy(occupancy)
    );

    exe_mem_pipe_reg #(.DATA_W(64), .ADDR_W(32), .DEST_W(5)) u_dut_wide (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .wb_en_in(1'b1), .mem_read_en_in(1'b0), .mem_write_en_in(1'b0),
        .alu_res_in(w_alu_in), .val_rm_in(~w_alu_in), .br_addr_in(32'h0000_1234), .dest_in(w_dest_in),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .wb_en(w_wb), .mem_read_en(w_rd), .mem_write_en(w_wr),
        .alu_res(w_alu), .val_rm(w_val), .br_addr(w_br), .dest(w_dest),
        .fwd_wb_en(w_fwd_wb), .fwd_dest(w_fwd_dest), .occupancy(w_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [3:0] d, input logic wb);
        in_valid        = v;
        alu_res_in      = alu;
        val_rm_in       = alu ^ 32'h5A5A_5A5A;
        br_addr_in      = alu + 32'h100;
        dest_in         = d;
        wb_en_in        = wb;
        mem_read_en_in  = alu[0];
        mem_write_en_in = alu[1];
    endtask

    // Scoreboard update for the coming edge, then advance to 1 time unit past it.
    task automatic step();
        ent_t act, exp, cur;
        bit   inf, outf;
        inf  = in_valid && in_ready;
        outf = out_valid && out_ready;
        cur  = {wb_en_in, mem_read_en_in, mem_write_en_in, alu_res_in, val_rm_in, br_addr_in, dest_in};
        if (outf) begin
            act = {wb_en, mem_read_en, mem_write_en, alu_res, val_rm, br_addr, dest};
            if (sb.size() == 0) begin
                check("pop_on_empty_scoreboard", 1, 0);
            end else begin
                exp = sb.pop_front();
                check("head_entry", act, exp);
            end
        end
        if (flush) sb.delete();
        else if (inf) sb.push_back(cur);
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_occ"},   occupancy, sb.size());
        check({tag, "_ready"}, in_ready, sb.size() < 2);
        check({tag, "_valid"}, out_valid, sb.size() > 0);
        check({tag, "_fwd"},   {fwd_wb_en, fwd_dest}, {wb_en, dest});
        if (!out_valid) check({tag, "_ctrl_gated"}, {wb_en, mem_read_en, mem_write_en}, 3'b000);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 4'h0, 1'b0);
        w_in_valid = 1'b0; w_out_ready = 1'b0; w_alu_in = '0; w_dest_in = '0;
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_occ", occupancy, 0);
        check("rst_outputs", {wb_en, mem_read_en, mem_write_en, alu_res, val_rm, br_addr, dest}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Stream with out_ready=1
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h10 + i, 4'(i + 1), 1'b1);
            step();
            check("stream_alu", alu_res, 32'h10 + i);
            check("stream_occ", occupancy, 1);
            check("stream_ready", in_ready, 1);
        end
        drive(1'b0, 32'h0, 4'h0, 1'b0);
        step();
        check_state("stream_end");

        // Backpressure fill
        out_ready = 1'b0;
        drive(1'b1, 32'hA0, 4'h2, 1'b1); step();
        drive(1'b1, 32'hA1, 4'h3, 1'b1); step();
        check("fill_occ", occupancy, 2);
        check("fill_ready", in_ready, 0);
        drive(1'b1, 32'hA2, 4'h4, 1'b1); step();
        check("fill_hold_alu", alu_res, 32'hA0);
        check_state("fill");
        drive(1'b0, 32'h0, 4'h0, 1'b0);

        // Drain from full
        out_ready = 1'b1;
        step();
        check("drain1_alu", alu_res, 32'hA1);
        check("drain1_ready", in_ready, 1);
        step();
        check("drain2_valid", out_valid, 0);
        check("drain2_wb", wb_en, 0);
        check_state("drain");

        // Flush with full buffer and an incoming entry
        out_ready = 1'b0;
        drive(1'b1, 32'hB0, 4'h6, 1'b1); step();
        drive(1'b1, 32'hB1, 4'h7, 1'b1); step();
        drive(1'b1, 32'hBB, 4'h5, 1'b1);
        flush = 1'b1; step(); flush = 1'b0;
        check("flush_valid", out_valid, 0);
        check("flush_wb", {wb_en, fwd_wb_en}, 2'b00);
        check("flush_occ", occupancy, 0);
        drive(1'b0, 32'h0, 4'h0, 1'b0);
        step(); step();
        check("flush_no_ghost", out_valid, 0);

        // Flush in ONE with simultaneous in_fire and out_fire
        drive(1'b1, 32'hD0, 4'h8, 1'b1); step();
        out_ready = 1'b1;
        drive(1'b1, 32'hD1, 4'h9, 1'b1);
        flush = 1'b1; step(); flush = 1'b0;
        drive(1'b0, 32'h0, 4'h0, 1'b0);
        check_state("flush_one");

        // Async reset while full
        out_ready = 1'b0;
        drive(1'b1, 32'hC0, 4'hA, 1'b1); step();
        drive(1'b1, 32'hC1, 4'hB, 1'b1); step();
        check("pre_rst_occ", occupancy, 2);
        drive(1'b0, 32'h0, 4'h0, 1'b0);
        #3 rst = 1'b1;
        #1;
        check("arst_outputs", {out_valid, wb_en, mem_read_en, mem_write_en, alu_res, val_rm, br_addr, dest, fwd_wb_en, fwd_dest}, 0);
        check("arst_ready", in_ready, 1);
        check("arst_occ", occupancy, 0);
        sb.delete();
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Random traffic against the scoreboard
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            step();
            flush = 1'b0;
            check_state("rand");
        end
        drive(1'b0, 32'h0, 4'h0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 6 && sb.size() != 0; i++) step();
        check("final_drain_empty", sb.size(), 0);
        check_state("final");

        // Wide parameter set
        w_in_valid = 1'b1; w_out_ready = 1'b1;
        w_alu_in = 64'hFFFF_FFFF_0000_0001; w_dest_in = 5'd31;
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        check("wide_valid", w_out_valid, 1);
        check("wide_alu", w_alu, 64'hFFFF_FFFF_0000_0001);
        check("wide_val", w_val, 64'h0000_0000_FFFF_FFFE);
        check("wide_dest", {w_fwd_wb, w_fwd_dest, w_dest}, {1'b1, 5'd31, 5'd31});
        @(posedge clk); #1;
        check("wide_drained", {w_out_valid, w_wb, w_occ, w_in_ready}, 5'b00001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
